// File: rtl/pipeFlow_pkg.sv
// rtl/pipeFlow_pkg.sv - shared pipeFlow stream types, widths and handshake helpers
package pipeFlow_pkg;

  localparam int PF_WORD_W = 5;
  localparam int PF_PACK_N = 4;
  localparam int PF_CNT_W  = $clog2(PF_PACK_N);

  // One packed beat as seen on the downstream side of a packer.
  typedef struct packed {
    logic [PF_WORD_W*PF_PACK_N-1:0] val;
    logic [PF_PACK_N-1:0]           keep;
    logic                           last;
  } pf_stream_t;

  typedef enum logic {
    PF_FILL = 1'b0,
    PF_FULL = 1'b1
  } pf_state_t;

  // A beat moves across a valid/ready port when both sides agree.
  function automatic logic pf_xfer(input logic valid, input logic rdy);
    return valid & rdy;
  endfunction

  // Lowest bit position of a lane inside a packed word.
  function automatic int pf_lane_lo(input int lane, input int word_w);
    return lane * word_w;
  endfunction

endpackage

// File: rtl/pipe_packer_lane_ctl.sv
// rtl/pipe_packer_lane_ctl.sv - fill counter, FILL/FULL state and handshake generation
module pipe_packer_lane_ctl
  import pipeFlow_pkg::*;
#(
  parameter int PACK_N = 4,
  localparam int CNT_W = $clog2(PACK_N)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             pipe_in_valid_i,
  input  logic             in_last_i,
  input  logic             pipe_out_rdy_i,
  output logic             pipe_in_rdy_o,
  output logic             pipe_out_valid_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             in_acc_o,
  output logic             clear_o,
  output logic             close_o
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_N - 1);

  pf_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and fill count; reset drops any partial pack at once.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= PF_FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshakes and next state; a held word leaving in the same cycle a new
  // word arrives lets the new word start the next pack without a bubble.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pipe_in_rdy_o = (state_q == PF_FILL) || pipe_out_rdy_i;
    in_acc_o      = pf_xfer(pipe_in_valid_i, pipe_in_rdy_o);
    clear_o       = pf_xfer(state_q == PF_FULL, pipe_out_rdy_i);
    close_o       = in_acc_o && ((cnt_q == LAST_LANE) || in_last_i);

    if (clear_o) begin
      state_d = PF_FILL;
    end
    if (in_acc_o) begin
      if (close_o) begin
        state_d = PF_FULL;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  assign pipe_out_valid_o = (state_q == PF_FULL);
  assign cnt_o            = cnt_q;

endmodule

// File: rtl/pipe_packer.sv
// rtl/pipe_packer.sv - packs PACK_N narrow words into one wide word (optional PIPE_PACKER_PARITY_EN)
module pipe_packer
  import pipeFlow_pkg::*;
#(
  parameter int WORD_W = PF_WORD_W,
  parameter int PACK_N = PF_PACK_N
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [WORD_W-1:0]        in_val,
  input  logic                     in_last,
  input  logic                     pipe_in_valid,
  output logic                     pipe_in_rdy,
  output logic [WORD_W*PACK_N-1:0] out_val,
  output logic [PACK_N-1:0]        out_keep,
  output logic                     out_last,
  output logic                     pipe_out_valid,
  input  logic                     pipe_out_rdy
`ifdef PIPE_PACKER_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  localparam int CNT_W = $clog2(PACK_N);

  logic [CNT_W-1:0]        cnt;
  logic                    in_acc;
  logic                    clear;
  logic                    close;

  logic [WORD_W*PACK_N-1:0] val_q, val_d;
  logic [PACK_N-1:0]        keep_q, keep_d;
  logic                     last_q, last_d;

  pipe_packer_lane_ctl #(
    .PACK_N (PACK_N)
  ) u_lane_ctl (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .pipe_in_valid_i  (pipe_in_valid),
    .in_last_i        (in_last),
    .pipe_out_rdy_i   (pipe_out_rdy),
    .pipe_in_rdy_o    (pipe_in_rdy),
    .pipe_out_valid_o (pipe_out_valid),
    .cnt_o            (cnt),
    .in_acc_o         (in_acc),
    .clear_o          (clear),
    .close_o          (close)
  );

  // Data next state: start from a cleared word when the held one leaves,
  // then drop an accepted word into lane cnt.
  always_comb begin
    val_d  = clear ? '0 : val_q;
    keep_d = clear ? '0 : keep_q;
    last_d = clear ? 1'b0 : last_q;
    if (in_acc) begin
      val_d[pf_lane_lo(int'(cnt), WORD_W) +: WORD_W] = in_val;
      keep_d[cnt]                                   = 1'b1;
    end
    if (close) begin
      last_d = in_last;
    end
  end

  // Packed data register; only changes on accept or departure, so it holds under stall.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      val_q  <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign out_val  = val_q;
  assign out_keep = keep_q;
  assign out_last = last_q;

`ifdef PIPE_PACKER_PARITY_EN
  logic parity_q;

  // Parity tracks the data register so it is valid and stable with out_val.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^val_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_pipe_packer.sv
// tb/tb_pipe_packer.sv - directed self-checking bench for pipe_packer
module tb_pipe_packer;
  import pipeFlow_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [4:0]  in_val;
  logic        in_last;
  logic        pipe_in_valid;
  logic        pipe_in_rdy;
  logic [19:0] out_val;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        pipe_out_valid;
  logic        pipe_out_rdy;
`ifdef PIPE_PACKER_PARITY_EN
  logic        out_parity;
`endif

  int checks = 0;
  int errors = 0;

  pf_stream_t exp_s;
  pf_stream_t held_s;

  pipe_packer #(
    .WORD_W (5),
    .PACK_N (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .in_val         (in_val),
    .in_last        (in_last),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_rdy    (pipe_in_rdy),
    .out_val        (out_val),
    .out_keep       (out_keep),
    .out_last       (out_last),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_rdy   (pipe_out_rdy)
`ifdef PIPE_PACKER_PARITY_EN
    ,
    .out_parity     (out_parity)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_beat(input string tag, input logic valid, input pf_stream_t e);
    check({tag, "_valid"}, 32'(pipe_out_valid), 32'(valid));
    check({tag, "_val"},   32'(out_val),        32'(e.val));
    check({tag, "_keep"},  32'(out_keep),       32'(e.keep));
    check({tag, "_last"},  32'(out_last),       32'(e.last));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [4:0] v, input logic last);
    in_val        = v;
    in_last       = last;
    pipe_in_valid = 1'b1;
  endtask

  task automatic idle();
    in_val        = 5'd0;
    in_last       = 1'b0;
    pipe_in_valid = 1'b0;
  endtask

  initial begin
    reset_ni     = 1'b0;
    pipe_out_rdy = 1'b1;
    idle();
    repeat (3) step();

    // Reset state
    exp_s = '{val: 20'h0, keep: 4'b0000, last: 1'b0};
    check_beat("reset", 1'b0, exp_s);
    check("reset_in_rdy", 32'(pipe_in_rdy), 32'd1);
    reset_ni = 1'b1;

    // 1: full pack 1,2,3,4 streaming
    drive(5'd1, 1'b0); step();
    check("s1_lat1", 32'(pipe_out_valid), 32'd0);
    drive(5'd2, 1'b0); step();
    drive(5'd3, 1'b0); step();
    check("s1_lat3", 32'(pipe_out_valid), 32'd0);
    drive(5'd4, 1'b0); step();
    idle();
    exp_s = '{val: 20'h20C41, keep: 4'b1111, last: 1'b0};
    check_beat("s1", 1'b1, exp_s);
`ifdef PIPE_PACKER_PARITY_EN
    check("s1_parity", 32'(out_parity), 32'd1);
`endif
    step();
    exp_s = '{val: 20'h0, keep: 4'b0000, last: 1'b0};
    check_beat("s1_after", 1'b0, exp_s);

    // 2: short packet 7,9 with last
    drive(5'd7, 1'b0); step();
    drive(5'd9, 1'b1); step();
    idle();
    exp_s = '{val: 20'h00127, keep: 4'b0011, last: 1'b1};
    check_beat("s2", 1'b1, exp_s);
    step();
    check("s2_after_valid", 32'(pipe_out_valid), 32'd0);

    // 3: stall with full pack, then simultaneous departure and new word
    pipe_out_rdy = 1'b0;
    drive(5'd1, 1'b0); step();
    drive(5'd2, 1'b0); step();
    drive(5'd3, 1'b0); step();
    drive(5'd4, 1'b0); step();
    idle();
    check("s3_in_rdy_stall", 32'(pipe_in_rdy), 32'd0);
    held_s = '{val: 20'h20C41, keep: 4'b1111, last: 1'b0};
    for (int i = 0; i < 10; i++) begin
      step();
      check_beat("s3_hold", 1'b1, held_s);
    end
    pipe_out_rdy = 1'b1;
    drive(5'd5, 1'b0);
    #1;
    check("s3_in_rdy_go", 32'(pipe_in_rdy), 32'd1);
    step();
    idle();
    exp_s = '{val: 20'h00005, keep: 4'b0001, last: 1'b0};
    check_beat("s3_lane0", 1'b0, exp_s);
    drive(5'd6, 1'b1); step();
    idle();
    exp_s = '{val: 20'h000C5, keep: 4'b0011, last: 1'b1};
    check_beat("s3_next", 1'b1, exp_s);
    step();

    // 4: back-to-back single-word packets
    drive(5'h1F, 1'b1); step();
    exp_s = '{val: 20'h0001F, keep: 4'b0001, last: 1'b1};
    check_beat("s4_a", 1'b1, exp_s);
    drive(5'h0A, 1'b1);
    #1;
    check("s4_in_rdy", 32'(pipe_in_rdy), 32'd1);
    step();
    idle();
    exp_s = '{val: 20'h0000A, keep: 4'b0001, last: 1'b1};
    check_beat("s4_b", 1'b1, exp_s);
    step();
    check("s4_after_valid", 32'(pipe_out_valid), 32'd0);

    // 5: asynchronous reset mid-packet, then a clean full pack
    drive(5'd11, 1'b0); step();
    drive(5'd12, 1'b0); step();
    idle();
    check("s5_partial", 32'(out_val), 32'h0018B);
    #2;
    reset_ni = 1'b0;
    #1;
    exp_s = '{val: 20'h0, keep: 4'b0000, last: 1'b0};
    check_beat("s5_rst", 1'b0, exp_s);
    #1;
    reset_ni = 1'b1;
    drive(5'd11, 1'b0); step();
    drive(5'd12, 1'b0); step();
    drive(5'd13, 1'b0); step();
    drive(5'd14, 1'b0); step();
    idle();
    exp_s = '{val: 20'h7358B, keep: 4'b1111, last: 1'b0};
    check_beat("s5", 1'b1, exp_s);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
